pc_counter: RTL and testbench

PC_COUNTER -- requirements
Module: pc_counter

---
 rtl/pc_counter.sv | 77 +++++++
 tb/tb_pc_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_counter.sv
// pc_counter: loadable up/down program counter with
// modulo or saturating limits, carry pulse and sticky overflow.
module pc_counter #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned STEP      = 1,
   parameter bit          SATURATE  = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             inc,
   input  logic             dec,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             ovf
);

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] out_nx;
   logic             carry_nx;
   logic             ovf_nx;
   logic             do_up;
   logic             do_dn;

   assign do_up = inc & ~dec;
   assign do_dn = dec & ~inc;

   // One extra bit catches the crossing on both adder and subtractor
   assign sum  = {1'b0, out} + STEP_X;
   assign diff = {1'b0, out} - STEP_X;

   // Next-state selection: load > count > hold (reset handled in the register)
   always_comb begin
      out_nx   = out;
      carry_nx = 1'b0;
      ovf_nx   = ovf;
      if (load) begin
         out_nx = in;
         ovf_nx = 1'b0;
      end else if (do_up) begin
         if (sum[WIDTH]) begin
            carry_nx = 1'b1;
            ovf_nx   = 1'b1;
            out_nx   = SATURATE ? '1 : sum[WIDTH-1:0];
         end else begin
            out_nx = sum[WIDTH-1:0];
         end
      end else if (do_dn) begin
         if (diff[WIDTH]) begin
            carry_nx = 1'b1;
            ovf_nx   = 1'b1;
            out_nx   = SATURATE ? '0 : diff[WIDTH-1:0];
         end else begin
            out_nx = diff[WIDTH-1:0];
         end
      end
   end

   // Single register set; synchronous reset overrides every other action
   always_ff @(posedge clk) begin
      if (reset) begin
         out   <= RESET_VAL;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         out   <= out_nx;
         carry <= carry_nx;
         ovf   <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_pc_counter.sv
// tb_pc_counter: three pc_counter variants (default, STEP=3,
// saturating) driven in lockstep and checked against a model.
module tb_pc_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic        inc = 1'b0;
   logic        dec = 1'b0;
   logic [15:0] in = '0;
   logic [15:0] d_out [3];
   logic        d_c [3];
   logic        d_o [3];

   int vectors = 0;
   int errors  = 0;

   // reference model state, one slot per variant
   longint m_out [3];
   bit     m_c [3];
   bit     m_o [3];
   longint steps [3] = '{1, 3, 1};
   bit     sats [3]  = '{0, 0, 1};
   localparam longint MAXV = 65535;

   always #5 clk = ~clk;

   pc_counter u0 (
      .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec),
      .in(in), .out(d_out[0]), .carry(d_c[0]), .ovf(d_o[0]));

   pc_counter #(.STEP(3)) u1 (
      .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec),
      .in(in), .out(d_out[1]), .carry(d_c[1]), .ovf(d_o[1]));

   pc_counter #(.SATURATE(1'b1)) u2 (
      .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec),
      .in(in), .out(d_out[2]), .carry(d_c[2]), .ovf(d_o[2]));

   task automatic model(input int k);
      longint v;
      if (reset) begin
         m_out[k] = 0; m_c[k] = 0; m_o[k] = 0;
      end else if (load) begin
         m_out[k] = in; m_c[k] = 0; m_o[k] = 0;
      end else if (inc && !dec) begin
         v = m_out[k] + steps[k];
         m_c[k] = (v > MAXV);
         if (v > MAXV) begin
            m_o[k] = 1;
            v = sats[k] ? MAXV : v - (MAXV + 1);
         end
         m_out[k] = v;
      end else if (dec && !inc) begin
         v = m_out[k] - steps[k];
         m_c[k] = (v < 0);
         if (v < 0) begin
            m_o[k] = 1;
            v = sats[k] ? 0 : v + (MAXV + 1);
         end
         m_out[k] = v;
      end else begin
         m_c[k] = 0;
      end
   endtask

   // drive one edge, advance the model, land 1 time unit after the edge
   task automatic apply(input bit r, input bit l, input bit i,
                        input bit d, input logic [15:0] v);
      reset = r; load = l; inc = i; dec = d; in = v;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model(k);
      #1;
      $display("| %016b | %016b |", in, d_out[0]);
   endtask

   task automatic test_reset;
      apply(1, 1, 1, 0, 16'h1234);
      vectors++;
      if (d_out[0] !== 16'h0000) begin
         errors++; $display("FAIL reset_out got %h want 0000", d_out[0]);
      end
      vectors++;
      if (d_c[0] !== 1'b0 || d_o[0] !== 1'b0) begin
         errors++; $display("FAIL reset_flags got c=%b o=%b want 0 0", d_c[0], d_o[0]);
      end
   endtask

   task automatic test_wrap_up;
      apply(0, 1, 0, 0, 16'hFFFF);
      apply(0, 0, 1, 0, 16'h0000);
      vectors++;
      if (d_out[0] !== 16'h0000 || d_c[0] !== 1'b1 || d_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_up got %h c=%b o=%b want 0000 1 1", d_out[0], d_c[0], d_o[0]);
      end
      for (int n = 0; n < 3; n++) begin
         apply(0, 0, 0, 0, 16'h0000);
         vectors++;
         if (d_c[0] !== 1'b0 || d_o[0] !== 1'b1 || d_out[0] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_hold%0d got %h c=%b o=%b want 0000 0 1", n, d_out[0], d_c[0], d_o[0]);
         end
      end
   endtask

   task automatic test_wrap_step;
      apply(0, 1, 0, 0, 16'h0001);
      apply(0, 0, 0, 1, 16'h0000);
      vectors++;
      if (d_out[1] !== 16'hFFFE || d_c[1] !== 1'b1) begin
         errors++; $display("FAIL step_dec got %h c=%b want fffe 1", d_out[1], d_c[1]);
      end
      apply(0, 0, 1, 0, 16'h0000);
      vectors++;
      if (d_out[1] !== 16'h0001 || d_c[1] !== 1'b1) begin
         errors++; $display("FAIL step_inc got %h c=%b want 0001 1", d_out[1], d_c[1]);
      end
   endtask

   task automatic test_saturate;
      logic [15:0] eo [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
      bit          ec [3] = '{0, 1, 1};
      apply(0, 1, 0, 0, 16'hFFFE);
      for (int n = 0; n < 3; n++) begin
         apply(0, 0, 1, 0, 16'h0000);
         vectors++;
         if (d_out[2] !== eo[n] || d_c[2] !== ec[n]) begin
            errors++;
            $display("FAIL sat_inc%0d got %h c=%b want %h %b", n, d_out[2], d_c[2], eo[n], ec[n]);
         end
      end
      vectors++;
      if (d_o[2] !== 1'b1) begin
         errors++; $display("FAIL sat_ovf got %b want 1", d_o[2]);
      end
      apply(0, 1, 0, 0, 16'h0000);
      apply(0, 0, 0, 1, 16'h0000);
      vectors++;
      if (d_out[2] !== 16'h0000 || d_c[2] !== 1'b1) begin
         errors++; $display("FAIL sat_dec got %h c=%b want 0000 1", d_out[2], d_c[2]);
      end
   endtask

   task automatic test_conflict;
      apply(0, 1, 0, 0, 16'hAAAA);
      apply(0, 0, 1, 1, 16'h0000);
      vectors++;
      if (d_out[0] !== 16'hAAAA || d_c[0] !== 1'b0) begin
         errors++; $display("FAIL both got %h c=%b want aaaa 0", d_out[0], d_c[0]);
      end
      apply(0, 0, 1, 0, 16'h0000);
      apply(0, 1, 1, 0, 16'h5555);
      vectors++;
      if (d_out[0] !== 16'h5555 || d_o[0] !== 1'b0) begin
         errors++; $display("FAIL load_inc got %h o=%b want 5555 0", d_out[0], d_o[0]);
      end
   endtask

   task automatic test_plain;
      apply(0, 1, 0, 0, 16'h7FFF);
      apply(0, 0, 1, 0, 16'h0000);
      vectors++;
      if (d_out[0] !== 16'h8000 || d_c[0] !== 1'b0 || d_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL plain got %h c=%b o=%b want 8000 0 0", d_out[0], d_c[0], d_o[0]);
      end
   endtask

   task automatic test_back_to_back;
      apply(0, 1, 0, 0, 16'hFFFF);
      apply(0, 0, 1, 0, 16'h0000);
      apply(0, 0, 1, 0, 16'h0000);
      vectors++;
      if (d_c[0] !== 1'b0 || d_out[0] !== 16'h0001) begin
         errors++; $display("FAIL b2b_wrap got %h c=%b want 0001 0", d_out[0], d_c[0]);
      end
      vectors++;
      if (d_c[2] !== 1'b1 || d_out[2] !== 16'hFFFF) begin
         errors++; $display("FAIL b2b_sat got %h c=%b want ffff 1", d_out[2], d_c[2]);
      end
      apply(1, 0, 1, 0, 16'h0000);
      vectors++;
      if (d_out[0] !== 16'h0000 || d_c[2] !== 1'b0 || d_o[2] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got %h c=%b o=%b want 0000 0 0", d_out[0], d_c[2], d_o[2]);
      end
      apply(0, 0, 1, 0, 16'h0000);
      vectors++;
      if (d_out[0] !== 16'h0001 || d_out[1] !== 16'h0003) begin
         errors++; $display("FAIL resume got %h %h want 0001 0003", d_out[0], d_out[1]);
      end
   endtask

   task automatic test_random;
      logic [15:0] v;
      for (int n = 0; n < 400; n++) begin
         v = 16'($urandom);
         if (n % 5 == 0) v = ($urandom_range(1) != 0) ? 16'hFFFF - 16'($urandom_range(3)) : 16'($urandom_range(3));
         apply($urandom_range(49) == 0, $urandom_range(9) == 0,
               $urandom_range(2) != 0, $urandom_range(2) != 0, v);
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (d_out[k] !== 16'(m_out[k]) || d_c[k] !== m_c[k] || d_o[k] !== m_o[k]) begin
               errors++;
               $display("FAIL rand%0d_u%0d got %h c=%b o=%b want %h %b %b", n, k,
                        d_out[k], d_c[k], d_o[k], 16'(m_out[k]), m_c[k], m_o[k]);
            end
         end
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_wrap_up();
      test_wrap_step();
      test_saturate();
      test_conflict();
      test_plain();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
